// File: rtl/glitch_pkg.sv
// Shared state encoding, default campaign constants and saturating helpers.
// Pure declarations: no latency, no flow control.
package glitch_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        COUNT   = 3'd2,
        GLITCH  = 3'd3,
        OBSERVE = 3'd4,
        ADVANCE = 3'd5,
        DONE    = 3'd6
    } seqState_t;

    localparam int unsigned DEF_START_OFFSET = 6500000;
    localparam int unsigned DEF_STEP         = 10000;
    localparam int unsigned DEF_WIDTH        = 100;
    localparam int unsigned DEF_NUM_ATTEMPTS = 4537;
    localparam int unsigned DEF_DOWN_TIME    = 200000;

    function automatic logic [31:0] satAdd32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

    function automatic logic [15:0] satInc16(input logic [15:0] a);
        return (a == 16'hFFFF) ? a : a + 16'd1;
    endfunction

endpackage

// File: rtl/glitch_window_timer.sv
// Free-running attempt timer with offset/width window compare; window_active is the registered glitch select.
// Window opens the cycle timer==offset, closes after width cycles; halt drops it on the next edge. No backpressure.
module glitch_window_timer (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        load,
    input  logic        halt,
    input  logic [31:0] offset,
    input  logic [31:0] width,
    output logic        window_active,
    output logic        window_start,
    output logic        window_end
);

    logic [31:0] timer;
    logic        running;
    logic [31:0] elapsed;

    // Modular difference keeps the end compare correct even if offset+width wraps.
    assign elapsed      = timer - offset;
    assign window_start = running && !window_active && (timer == offset - 32'd1);
    assign window_end   = window_active && (elapsed == width - 32'd1);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            timer         <= '0;
            running       <= 1'b0;
            window_active <= 1'b0;
        end else if (load) begin
            timer         <= '0;
            running       <= 1'b1;
            window_active <= (offset == 32'd0);
        end else if (halt) begin
            running       <= 1'b0;
            window_active <= 1'b0;
        end else if (running) begin
            timer <= timer + 32'd1;
            if (window_end) begin
                window_active <= 1'b0;
                running       <= 1'b0;
            end else if (window_start) begin
                window_active <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/glitch_campaign_sequencer.sv
// Campaign FSM: arms on reader power-up, fires one glitch window per attempt, waits for card reset, steps offset.
// glitch_en is registered (one cycle after the deciding edge); start/abort are pulses, no backpressure.
module glitch_campaign_sequencer
    import glitch_pkg::*;
#(
    parameter int unsigned START_OFFSET = DEF_START_OFFSET,
    parameter int unsigned STEP         = DEF_STEP,
    parameter int unsigned WIDTH        = DEF_WIDTH,
    parameter int unsigned NUM_ATTEMPTS = DEF_NUM_ATTEMPTS,
    parameter int unsigned DOWN_TIME    = DEF_DOWN_TIME
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        reader_active,
    output logic        glitch_en,
    output logic        busy,
    output logic        done,
    output logic [31:0] cur_offset,
    output logic [15:0] attempt_count
);

    seqState_t   state, nextState;
    logic        readerPrev;
    logic        readerRise;
    logic        readerLost;
    logic        attemptVoid;
    logic [31:0] downCnt;
    logic        loadTimer;
    logic        haltTimer;
    logic        windowStart;
    logic        windowEnd;
    logic        startAccepted;

    assign readerRise    = reader_active && !readerPrev;
    assign readerLost    = ((state == COUNT) || (state == GLITCH)) && !reader_active;
    assign startAccepted = start && !abort && ((state == IDLE) || (state == DONE));
    assign busy          = (state != IDLE) && (state != DONE);
    assign done          = (state == DONE);

    glitch_window_timer u_timer (
        .clock         (clock),
        .rst_n         (rst_n),
        .load          (loadTimer),
        .halt          (haltTimer),
        .offset        (cur_offset),
        .width         (32'(WIDTH)),
        .window_active (glitch_en),
        .window_start  (windowStart),
        .window_end    (windowEnd)
    );

    always_comb begin
        nextState = state;
        loadTimer = 1'b0;
        haltTimer = abort || readerLost;
        if (abort) begin
            nextState = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) nextState = ARM;
                end
                ARM: begin
                    if (readerRise) begin
                        loadTimer = 1'b1;
                        nextState = (cur_offset == 32'd0) ? GLITCH : COUNT;
                    end
                end
                COUNT: begin
                    if (!reader_active)   nextState = OBSERVE;
                    else if (windowStart) nextState = GLITCH;
                end
                GLITCH: begin
                    if (!reader_active || windowEnd) nextState = OBSERVE;
                end
                OBSERVE: begin
                    if (!reader_active && (downCnt + 32'd1 >= 32'(DOWN_TIME)))
                        nextState = ADVANCE;
                end
                ADVANCE: begin
                    if (!attemptVoid && (satInc16(attempt_count) == 16'(NUM_ATTEMPTS)))
                        nextState = DONE;
                    else
                        nextState = ARM;
                end
                default: nextState = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            readerPrev    <= 1'b0;
            attemptVoid   <= 1'b0;
            downCnt       <= '0;
            cur_offset    <= '0;
            attempt_count <= '0;
        end else begin
            state      <= nextState;
            readerPrev <= reader_active;

            // Down counter only advances on consecutive inactive samples while observing.
            if (state == OBSERVE && !abort)
                downCnt <= reader_active ? 32'd0 : downCnt + 32'd1;
            else
                downCnt <= '0;

            if (startAccepted) begin
                cur_offset    <= 32'(START_OFFSET);
                attempt_count <= '0;
            end

            if (!abort) begin
                if (state == ARM && readerRise)
                    attemptVoid <= 1'b0;
                if (readerLost)
                    attemptVoid <= 1'b1;
                if (state == ADVANCE && !attemptVoid) begin
                    attempt_count <= satInc16(attempt_count);
                    cur_offset    <= satAdd32(cur_offset, 32'(STEP));
                end
            end
        end
    end

endmodule

// File: tb/tb_glitch_campaign_sequencer.sv
// Directed bench: run-length vector table for a full two-attempt campaign, plus hand sequences
// for reader drop, abort, level-on-entry, start/abort collision, down-count restart and async reset.
module tb_glitch_campaign_sequencer;

    logic        clock;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        reader_active;
    logic        glitch_en;
    logic        busy;
    logic        done;
    logic [31:0] cur_offset;
    logic [15:0] attempt_count;

    int nChecks = 0;
    int nFails  = 0;

    glitch_campaign_sequencer #(
        .START_OFFSET (20),
        .STEP         (5),
        .WIDTH        (3),
        .NUM_ATTEMPTS (2),
        .DOWN_TIME    (10)
    ) dut (
        .clock         (clock),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .reader_active (reader_active),
        .glitch_en     (glitch_en),
        .busy          (busy),
        .done          (done),
        .cur_offset    (cur_offset),
        .attempt_count (attempt_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        reader;
        int          cycles;
        logic        glitch;
        logic        busy;
        logic        done;
        logic [15:0] cnt;
        logic [31:0] off;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic sawGlitch;

        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        reader_active = 1'b0;

        // Full campaign: {reader, cycles, glitch_en each cycle, busy, done, attempt_count, cur_offset at end}
        tbl.push_back('{1'b0,  3, 1'b0, 1'b1, 1'b0, 16'd0, 32'd20});
        tbl.push_back('{1'b1, 20, 1'b0, 1'b1, 1'b0, 16'd0, 32'd20});
        tbl.push_back('{1'b1,  3, 1'b1, 1'b1, 1'b0, 16'd0, 32'd20});
        tbl.push_back('{1'b1,  2, 1'b0, 1'b1, 1'b0, 16'd0, 32'd20});
        tbl.push_back('{1'b0, 10, 1'b0, 1'b1, 1'b0, 16'd0, 32'd20});
        tbl.push_back('{1'b0,  1, 1'b0, 1'b1, 1'b0, 16'd1, 32'd25});
        tbl.push_back('{1'b0,  2, 1'b0, 1'b1, 1'b0, 16'd1, 32'd25});
        tbl.push_back('{1'b1, 25, 1'b0, 1'b1, 1'b0, 16'd1, 32'd25});
        tbl.push_back('{1'b1,  3, 1'b1, 1'b1, 1'b0, 16'd1, 32'd25});
        tbl.push_back('{1'b1,  1, 1'b0, 1'b1, 1'b0, 16'd1, 32'd25});
        tbl.push_back('{1'b0, 10, 1'b0, 1'b1, 1'b0, 16'd1, 32'd25});
        tbl.push_back('{1'b0,  1, 1'b0, 1'b0, 1'b1, 16'd2, 32'd30});
        tbl.push_back('{1'b0,  2, 1'b0, 1'b0, 1'b1, 16'd2, 32'd30});

        // Reset state
        repeat (3) tick();
        check("rst_glitch_en", 32'(glitch_en), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_cur_offset", cur_offset, 0);
        check("rst_attempt_count", 32'(attempt_count), 0);
        rst_n = 1'b1;
        tick();

        // Campaign from the table
        pulseStart();
        check("start_busy", 32'(busy), 1);
        check("start_offset", cur_offset, 20);
        check("start_count", 32'(attempt_count), 0);
        for (int i = 0; i < tbl.size(); i++) begin
            reader_active = tbl[i].reader;
            for (int c = 0; c < tbl[i].cycles; c++) begin
                tick();
                check($sformatf("vec%0d_cyc%0d_glitch_en", i, c), 32'(glitch_en), 32'(tbl[i].glitch));
            end
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
            check($sformatf("vec%0d_done", i), 32'(done), 32'(tbl[i].done));
            check($sformatf("vec%0d_count", i), 32'(attempt_count), 32'(tbl[i].cnt));
            check($sformatf("vec%0d_offset", i), cur_offset, tbl[i].off);
        end

        // Reader drops inside the window: attempt voided, same offset retried
        pulseStart();
        check("restart_from_done_count", 32'(attempt_count), 0);
        check("restart_from_done_offset", cur_offset, 20);
        check("restart_from_done_done", 32'(done), 0);
        tick();
        reader_active = 1'b1;
        repeat (22) tick();
        check("drop_pre_glitch_en", 32'(glitch_en), 1);
        reader_active = 1'b0;
        tick();
        check("drop_glitch_en_low", 32'(glitch_en), 0);
        check("drop_busy", 32'(busy), 1);
        repeat (11) tick();
        check("drop_count_held", 32'(attempt_count), 0);
        check("drop_offset_held", cur_offset, 20);
        check("drop_busy_rearmed", 32'(busy), 1);
        reader_active = 1'b1;
        repeat (20) tick();
        check("retry_before_window", 32'(glitch_en), 0);
        tick();
        check("retry_window_same_offset", 32'(glitch_en), 1);
        repeat (3) tick();
        check("retry_window_closed", 32'(glitch_en), 0);

        // Abort in OBSERVE, then abort inside the glitch window
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_obs_busy", 32'(busy), 0);
        check("abort_obs_done", 32'(done), 0);
        check("abort_obs_offset_held", cur_offset, 20);
        pulseStart();
        reader_active = 1'b0;
        tick();
        reader_active = 1'b1;
        repeat (22) tick();
        check("abort_pre_glitch_en", 32'(glitch_en), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_glitch_en", 32'(glitch_en), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        sawGlitch = 1'b0;
        repeat (5) begin
            tick();
            sawGlitch = sawGlitch | glitch_en | busy;
        end
        check("abort_stays_idle", 32'(sawGlitch), 0);
        pulseStart();
        check("abort_restart_offset", cur_offset, 20);
        check("abort_restart_busy", 32'(busy), 1);

        // Reader already high on entry to ARM is not an edge
        sawGlitch = 1'b0;
        repeat (30) begin
            tick();
            sawGlitch = sawGlitch | glitch_en;
        end
        check("arm_level_no_edge", 32'(sawGlitch), 0);
        check("arm_level_busy", 32'(busy), 1);

        // start together with abort: abort wins
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_busy", 32'(busy), 0);
        check("start_abort_done", 32'(done), 0);

        // Down counter restarts on a high pulse at inactive cycle 7
        reader_active = 1'b0;
        pulseStart();
        tick();
        reader_active = 1'b1;
        repeat (24) tick();
        check("pulse_in_observe", 32'(glitch_en), 0);
        reader_active = 1'b0;
        repeat (6) tick();
        reader_active = 1'b1;
        tick();
        reader_active = 1'b0;
        repeat (4) tick();
        check("pulse_no_early_advance", 32'(attempt_count), 0);
        repeat (6) tick();
        check("pulse_count_before_advance", 32'(attempt_count), 0);
        tick();
        check("pulse_count_after_advance", 32'(attempt_count), 1);
        check("pulse_offset_after_advance", cur_offset, 25);

        // Asynchronous reset during GLITCH
        reader_active = 1'b1;
        repeat (26) tick();
        check("rst_pre_glitch_en", 32'(glitch_en), 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_glitch_en", 32'(glitch_en), 0);
        check("async_rst_busy", 32'(busy), 0);
        check("async_rst_done", 32'(done), 0);
        check("async_rst_offset", cur_offset, 0);
        check("async_rst_count", 32'(attempt_count), 0);
        tick();
        rst_n = 1'b1;
        reader_active = 1'b0;
        tick();
        reader_active = 1'b1;
        sawGlitch = 1'b0;
        repeat (30) begin
            tick();
            sawGlitch = sawGlitch | glitch_en | busy;
        end
        check("no_resume_after_reset", 32'(sawGlitch), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
